// File: rtl/phase_sampler.sv
// Phase sampler for the coupled-oscillator array: releases the array, lets it settle,
// counts per-spin phase agreement with the reference, then latches majority spin bits.
module phase_sampler #(
  parameter int unsigned N           = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] sample_cycles,
  input  logic [N-1:0]     phase_in,
  input  logic             phase_ref,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spins,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE
  } state_t;

  logic [N-1:0]     r_sp_sync [SYNC_N];
  logic [SYNC_N-1:0] r_sr_sync;
  logic [N-1:0]     w_sp;
  logic             w_sr;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nx;
  logic [CNT_W-1:0] r_se;
  logic [CNT_W-1:0] r_me;
  logic [CNT_W-1:0] w_se_in;
  logic [CNT_W-1:0] w_me_in;
  logic             w_clr;
  logic             w_sample;
  logic             w_decide;
  logic             w_busy_nx;
  logic             w_rstn_nx;
  logic             w_done_nx;

  logic             r_busy;
  logic             r_rstn;
  logic             r_done;
  logic [N-1:0]     r_spins;
  logic [CNT_W-1:0] r_count [N];
  logic [CNT_W-1:0] w_rd_count;

  // Free-running synchronisers; equal depth keeps phase_in and phase_ref aligned.
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int s = 0; s < int'(SYNC_N); s++) begin
        r_sp_sync[s] <= '0;
      end
      r_sr_sync <= '0;
    end else begin
      r_sp_sync[0] <= phase_in;
      for (int s = 1; s < int'(SYNC_N); s++) begin
        r_sp_sync[s] <= r_sp_sync[s-1];
      end
      r_sr_sync <= {r_sr_sync[SYNC_N-2:0], phase_ref};
    end
  end

  assign w_sp = r_sp_sync[SYNC_N-1];
  assign w_sr = r_sr_sync[SYNC_N-1];

  // Zero-length requests are stretched to one cycle.
  assign w_se_in = (settle_cycles == '0) ? CNT_W'(1) : settle_cycles;
  assign w_me_in = (sample_cycles == '0) ? CNT_W'(1) : sample_cycles;

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_se    <= CNT_W'(1);
      r_me    <= CNT_W'(1);
      r_busy  <= 1'b0;
      r_rstn  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_busy  <= w_busy_nx;
      r_rstn  <= w_rstn_nx;
      r_done  <= w_done_nx;
      if (w_clr) begin
        r_se <= w_se_in;
        r_me <= w_me_in;
      end
    end
  end

  // Next state, phase timer and registered-output next values.
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_clr      = 1'b0;
    w_sample   = 1'b0;
    w_decide   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_SETTLE;
          w_timer_nx = '0;
          w_clr      = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_timer == r_se - CNT_W'(1)) begin
          w_state_nx = S_SAMPLE;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_sample = 1'b1;
        if (r_timer == r_me - CNT_W'(1)) begin
          w_state_nx = S_DECIDE;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + CNT_W'(1);
        end
      end
      S_DECIDE: begin
        w_decide   = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
    w_rstn_nx = (w_state_nx == S_SETTLE) || (w_state_nx == S_SAMPLE);
    w_done_nx = (w_state_nx == S_DECIDE);
  end

  // Match counters and strict-majority spin decision (doubling avoids a divide).
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int i = 0; i < int'(N); i++) begin
        r_count[i] <= '0;
      end
      r_spins <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (w_clr) begin
          r_count[i] <= '0;
        end else if (w_sample && (w_sp[i] == w_sr)) begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end
      end
      if (w_decide) begin
        for (int i = 0; i < int'(N); i++) begin
          r_spins[i] <= ({r_count[i], 1'b0} > {1'b0, r_me});
        end
      end
    end
  end

  always_comb begin
    w_rd_count = '0;
    if (32'(rd_idx) < N) begin
      w_rd_count = r_count[rd_idx];
    end
  end

  assign ising_rstn = r_rstn;
  assign busy       = r_busy;
  assign done       = r_done;
  assign spins      = r_spins;
  assign rd_count   = w_rd_count;

endmodule

// File: tb/tb_phase_sampler.sv
// Bench for phase_sampler: edge-numbered window model checked every cycle,
// plus directed runs with hand-computed results.
module tb_phase_sampler;

  localparam int N    = 8;
  localparam int CW   = 16;
  localparam int SS   = 2;
  localparam int MAXH = 4096;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] settle_cycles = '0;
  logic [CW-1:0] sample_cycles = '0;
  logic [N-1:0]  phase_in = '0;
  logic          phase_ref = 1'b0;
  logic [2:0]    rd_idx = '0;
  logic          ising_rstn;
  logic          busy;
  logic          done;
  logic [N-1:0]  spins;
  logic [CW-1:0] rd_count;

  int n_chk = 0;
  int n_err = 0;

  phase_sampler #(.N(N), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start),
    .settle_cycles(settle_cycles), .sample_cycles(sample_cycles),
    .phase_in(phase_in), .phase_ref(phase_ref),
    .ising_rstn(ising_rstn), .busy(busy), .done(done), .spins(spins),
    .rd_idx(rd_idx), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- phase pattern driver ----------------
  int   mode  = 0;
  bit   sweep = 1'b1;
  logic tg    = 1'b0;

  always @(negedge clk) begin
    tg = ~tg;
    if (sweep) rd_idx = rd_idx + 3'd1;
    case (mode)
      0: begin phase_ref = tg;   phase_in = {6'b0, ~tg, tg}; end
      1: begin phase_ref = 1'b0; phase_in = {5'b0, tg, 2'b0}; end
      default: {phase_ref, phase_in} = 9'($urandom);
    endcase
  end

  // ---------------- model: runs described by edge numbers ----------------
  // Edge k samples the inputs into hist[k]; the synchronised view during the
  // cycle after edge j is hist[j-SS+1] (zero if that predates the last reset).
  int         cyc = 0;
  int         rst_mark = 0;
  int         m_t = 0, m_se = 1, m_me = 1;
  bit         m_act = 0, m_busy = 0, m_done = 0, m_rstn = 0;
  logic [N-1:0] m_spins = '0;
  int         m_cnt [N];
  logic [N:0] hist [MAXH];

  function automatic logic [N:0] h(input int j);
    if (j < rst_mark || j < 0 || j >= MAXH) return '0;
    return hist[j];
  endfunction

  always @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      m_act = 0; m_busy = 0; m_done = 0; m_rstn = 0; m_spins = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      rst_mark = cyc;
    end else begin
      logic [N:0] s;
      bit prev_busy;
      if (cyc < MAXH) hist[cyc] = {phase_ref, phase_in};
      prev_busy = m_busy;
      if (m_act && (cyc - 1 >= m_t + m_se) && (cyc - 1 < m_t + m_se + m_me)) begin
        s = h(cyc - SS);
        for (int i = 0; i < N; i++) if (s[i] == s[N]) m_cnt[i]++;
      end
      if (m_act && cyc == m_t + m_se + m_me + 1) begin
        for (int i = 0; i < N; i++) m_spins[i] = (2 * m_cnt[i] > m_me);
        m_act = 0;
      end
      if (!prev_busy && start) begin
        m_act = 1;
        m_t   = cyc;
        m_se  = (settle_cycles == 0) ? 1 : int'(settle_cycles);
        m_me  = (sample_cycles == 0) ? 1 : int'(sample_cycles);
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      m_busy = m_act && (cyc <= m_t + m_se + m_me);
      m_rstn = m_act && (cyc <  m_t + m_se + m_me);
      m_done = m_act && (cyc == m_t + m_se + m_me);
      cyc++;
    end
  end

  // Every-cycle comparison, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    chk("busy", longint'(busy), longint'(m_busy));
    chk("done", longint'(done), longint'(m_done));
    chk("ising_rstn", longint'(ising_rstn), longint'(m_rstn));
    chk("spins", longint'(spins), longint'(m_spins));
    chk("rd_count", longint'(rd_count), longint'(m_cnt[rd_idx]));
  end

  // ---------------- directed stimulus ----------------
  task automatic do_run(input int se, input int me, input int se2, input int me2,
                        output int lat);
    @(negedge clk);
    settle_cycles = CW'(se);
    sample_cycles = CW'(me);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle_cycles = CW'(se2);
    sample_cycles = CW'(me2);
    lat = 0;
    while (done !== 1'b1 && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 500) chk("done within bound", longint'(done), 1);
    @(posedge clk); #2;
  endtask

  task automatic chk_rd(input string nm, input int idx, input int exp);
    sweep  = 1'b0;
    rd_idx = 3'(idx);
    #1;
    chk(nm, longint'(rd_count), exp);
  endtask

  initial begin
    int lat, nb, nr, nd;

    // Asynchronous reset before any clock edge.
    #2 axi_rst = 1'b1;
    #1;
    chk("reset ising_rstn", longint'(ising_rstn), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset spins", longint'(spins), 0);
    chk("reset rd_count", longint'(rd_count), 0);
    repeat (3) @(negedge clk);
    axi_rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic run: in0 follows ref, in1 opposes it, the rest held low.
    mode = 0;
    do_run(4, 10, 4, 10, lat);
    chk("basic done cycle", lat + 1, 15);
    chk("basic spins", longint'(spins), 'h01);
    chk_rd("basic rd0", 0, 10);
    chk_rd("basic rd1", 1, 0);
    sweep = 1'b1;

    // Tie: in2 alternating against a constant ref gives exactly half.
    mode = 1;
    do_run(4, 10, 4, 10, lat);
    chk("tie done cycle", lat + 1, 15);
    chk("tie spins", longint'(spins), 'hFB);
    chk("tie spin2", longint'(spins[2]), 0);
    chk_rd("tie rd2", 2, 5);
    sweep = 1'b1;

    // Capture: timer inputs changed during SETTLE must not affect the run.
    mode = 2;
    do_run(4, 10, 1, 3, lat);
    chk("capture done cycle", lat + 1, 15);
    chk_rd("capture rd0", 0, m_cnt[0]);
    chk("capture rd0 bound", longint'(rd_count <= 16'd10), 1);
    sweep = 1'b1;

    // Zero lengths, with start still high on the following (busy) edge.
    mode = 0;
    @(negedge clk);
    settle_cycles = '0;
    sample_cycles = '0;
    start = 1'b1;
    nb = 0; nr = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      nb += int'(busy);
      nr += int'(ising_rstn);
      nd += int'(done);
      if (i == 1) start = 1'b0;
    end
    chk("zero busy cycles", nb, 3);
    chk("zero ising_rstn cycles", nr, 2);
    chk("zero done pulses", nd, 1);
    chk("zero spin0", longint'(spins[0]), 1);
    chk("zero spin1", longint'(spins[1]), 0);

    // Mid-run abort during SAMPLE, then a clean run.
    @(negedge clk);
    settle_cycles = CW'(2);
    sample_cycles = CW'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 axi_rst = 1'b1;
    #1;
    chk("abort ising_rstn", longint'(ising_rstn), 0);
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    chk("abort spins", longint'(spins), 0);
    chk("abort rd_count", longint'(rd_count), 0);
    repeat (2) @(negedge clk);
    axi_rst = 1'b0;
    repeat (3) @(negedge clk);
    do_run(3, 8, 3, 8, lat);
    chk("post-abort done cycle", lat + 1, 12);
    chk("post-abort spins", longint'(spins), 'h01);
    chk_rd("post-abort rd0", 0, 8);
    chk_rd("post-abort rd1", 1, 0);
    sweep = 1'b1;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
